// File: rtl/key_cmd_queue_if.sv
// Command handshake between key_cmd_queue (master) and the game logic (slave).
//   cmd_valid : master -> slave, a command is presented on cmd_code
//   cmd_ready : slave -> master, head command is taken when cmd_valid=1
//   cmd_code  : master -> slave, 1=UP 2=DOWN 3=LEFT 4=RIGHT 5=ENTER, 0 when idle
interface key_cmd_queue_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready
    );
endinterface

// File: rtl/key_cmd_queue.sv
// Turns PS2 decoder key levels into discrete game commands with direction
// auto-repeat, buffered in a small FIFO behind a valid/ready handshake.
//   clk, rst          : clock, asynchronous active-high reset
//   i_up .. i_enter   : key levels, 1 = held (already in the clk domain)
//   cmd_if (master)   : cmd_valid / cmd_ready / cmd_code command stream
//   o_overflow        : sticky, a command was dropped on a full FIFO
module key_cmd_queue #(
    parameter int unsigned DELAY_CYC  = 25_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_left,
    input  logic                  i_right,
    input  logic                  i_enter,
    key_cmd_queue_if.master       cmd_if,
    output logic                  o_overflow
);

    localparam int unsigned NKEY    = 5;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned CNT_MAX = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX);

    localparam logic [CODE_W-1:0] C_NONE  = 3'd0;
    localparam logic [CODE_W-1:0] C_UP    = 3'd1;
    localparam logic [CODE_W-1:0] C_DOWN  = 3'd2;
    localparam logic [CODE_W-1:0] C_LEFT  = 3'd3;
    localparam logic [CODE_W-1:0] C_RIGHT = 3'd4;
    localparam logic [CODE_W-1:0] C_ENTER = 3'd5;

    // Key vector bit positions
    localparam int unsigned K_UP    = 0;
    localparam int unsigned K_DOWN  = 1;
    localparam int unsigned K_LEFT  = 2;
    localparam int unsigned K_RIGHT = 3;
    localparam int unsigned K_ENTER = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [NKEY-1:0]   w_keys;
    logic [NKEY-1:0]   r_k_q;
    logic [NKEY-1:0]   r_k_prev;
    logic [NKEY-1:0]   r_edge;

    logic [CODE_W-1:0] w_press_code;
    logic              w_press_valid;
    logic              w_press_dir;
    logic              w_active_held;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [CW-1:0]     w_term;
    logic [CODE_W-1:0] r_active;
    logic [CODE_W-1:0] w_active_nxt;
    logic              w_rep_push;

    logic              w_push;
    logic [CODE_W-1:0] w_push_code;

    logic [CODE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_overflow;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_en;

    assign w_keys = {i_enter, i_right, i_left, i_down, i_up};

    // Input register, history and registered press edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k_q    <= '0;
            r_k_prev <= '0;
            r_edge   <= '0;
        end else begin
            r_k_q    <= w_keys;
            r_k_prev <= r_k_q;
            r_edge   <= r_k_q & ~r_k_prev;
        end
    end

    // Priority select of simultaneous presses: ENTER > UP > DOWN > LEFT > RIGHT
    always_comb begin
        w_press_code = C_NONE;
        if (r_edge[K_ENTER])      w_press_code = C_ENTER;
        else if (r_edge[K_UP])    w_press_code = C_UP;
        else if (r_edge[K_DOWN])  w_press_code = C_DOWN;
        else if (r_edge[K_LEFT])  w_press_code = C_LEFT;
        else if (r_edge[K_RIGHT]) w_press_code = C_RIGHT;
    end

    assign w_press_valid = |r_edge;
    assign w_press_dir   = w_press_valid & ~r_edge[K_ENTER];

    // Level of the key currently being repeated
    always_comb begin
        w_active_held = 1'b0;
        case (r_active)
            C_UP:    w_active_held = r_k_q[K_UP];
            C_DOWN:  w_active_held = r_k_q[K_DOWN];
            C_LEFT:  w_active_held = r_k_q[K_LEFT];
            C_RIGHT: w_active_held = r_k_q[K_RIGHT];
            default: w_active_held = 1'b0;
        endcase
    end

    // Repeat FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_active <= C_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
        end
    end

    assign w_term = (r_state == S_DELAY) ? CW'(DELAY_CYC - 1) : CW'(REPEAT_CYC - 1);

    // Repeat FSM next state; a fresh direction press always restarts the delay
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_rep_push   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press_dir) begin
                    w_state_nxt  = S_DELAY;
                    w_active_nxt = w_press_code;
                    w_cnt_nxt    = '0;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (w_press_dir) begin
                    w_state_nxt  = S_DELAY;
                    w_active_nxt = w_press_code;
                    w_cnt_nxt    = '0;
                end else if (!w_active_held) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == w_term) begin
                    w_rep_push  = 1'b1;
                    w_state_nxt = S_REPEAT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // One push per cycle; a press wins over a coincident repeat (e.g. ENTER)
    assign w_push      = w_press_valid | w_rep_push;
    assign w_push_code = w_press_valid ? w_press_code : r_active;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & cmd_if.cmd_ready;
    // A pop in the same cycle frees the slot, so full+pop still accepts the push
    assign w_wr_en = w_push & (~w_full | w_pop);

    // Command FIFO storage, pointers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= C_NONE;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_push_code;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cmd_if.cmd_valid = ~w_empty;
    assign cmd_if.cmd_code  = w_empty ? C_NONE : r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow       = r_overflow;

endmodule
